// File: rtl/pcm_src_arbiter_if.sv
// pcm_src_arbiter_if
// Bundles the producer lanes and the FIFO write port shared by the
// sample-rate-paced PCM arbiter.
//   master : the arbiter side (drives acks and the FIFO write port)
//   slave  : the environment side (producers and FIFO)
interface pcm_src_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 16
);
   logic [NUM_SRC-1:0]        src_en;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_ack;
   logic                      fifo_full;
   logic                      fifo_wr;
   logic [DATA_W-1:0]         fifo_data;

   modport master (
      input  src_en, src_valid, src_data, fifo_full,
      output src_ack, fifo_wr, fifo_data
   );

   modport slave (
      output src_en, src_valid, src_data, fifo_full,
      input  src_ack, fifo_wr, fifo_data
   );
endinterface

// File: rtl/pcm_src_arbiter.sv
// pcm_src_arbiter
// Shares one PCM FIFO write port between NUM_SRC producers. Every
// sample_tick opens one arbitration slot; the slot is resolved round-robin
// (searching upward from the source after the last grant) as soon as the
// FIFO can take a write, and the winning sample is written and acked in a
// single registered cycle. Ticks that land while a slot is still waiting
// are counted as overruns; slots with no eligible source count as underruns.
// Optional build macro: PCM_ZERO_FILL_EN -- an underrun slot writes a zero
// sample (no ack, grant unchanged) so the DAC cadence is kept; without it
// the slot is skipped.
module pcm_src_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                aclr,
   input  logic                sample_tick,
   pcm_src_arbiter_if.master   bus,
   output logic [2:0]          grant_id,
   output logic [CNT_W-1:0]    underrun_cnt,
   output logic [CNT_W-1:0]    overrun_cnt
);

   typedef enum logic [1:0] {IDLE, ARB, WRITE} state_t;

   localparam logic [3:0]       NS4     = 4'(NUM_SRC);
   localparam logic [2:0]       GRANT_0 = 3'(NUM_SRC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              state_reg, state_next;
   logic                fifo_wr_reg, fifo_wr_next;
   logic [DATA_W-1:0]   fifo_data_reg, fifo_data_next;
   logic [NUM_SRC-1:0]  src_ack_reg, src_ack_next;
   logic [2:0]          grant_id_reg, grant_id_next;
   logic [CNT_W-1:0]    underrun_cnt_reg, underrun_cnt_next;
   logic [CNT_W-1:0]    overrun_cnt_reg, overrun_cnt_next;

   logic [NUM_SRC-1:0]  req;
   logic [DATA_W-1:0]   lane [NUM_SRC];
   logic                win_found;
   logic [2:0]          win_id;
   logic [DATA_W-1:0]   win_data;
   logic [NUM_SRC-1:0]  win_onehot;
   logic [3:0]          rr_idx;

   assign req = bus.src_valid & bus.src_en;

   // Unpack the sample lanes so the winner mux works on whole samples.
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
         assign lane[gi] = bus.src_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin pick: walk offsets from NUM_SRC down to 1 so the nearest
   // eligible source after the last grant is the final (winning) assignment.
   always_comb begin
      win_found  = 1'b0;
      win_id     = grant_id_reg;
      win_data   = '0;
      win_onehot = '0;
      rr_idx     = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         rr_idx = {1'b0, grant_id_reg} + 4'(k);
         if (rr_idx >= NS4) begin
            rr_idx = rr_idx - NS4;
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if ((rr_idx == 4'(i)) && req[i]) begin
               win_found     = 1'b1;
               win_id        = 3'(i);
               win_data      = lane[i];
               win_onehot    = '0;
               win_onehot[i] = 1'b1;
            end
         end
      end
   end

   // Next-state and registered-output logic for the slot FSM.
   always_comb begin
      state_next        = state_reg;
      fifo_wr_next      = 1'b0;
      fifo_data_next    = fifo_data_reg;
      src_ack_next      = '0;
      grant_id_next     = grant_id_reg;
      underrun_cnt_next = underrun_cnt_reg;
      overrun_cnt_next  = overrun_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (sample_tick) begin
               state_next = ARB;
            end
         end
         ARB: begin
            // A tick here always collapses into the slot already waiting,
            // whether or not the FIFO releases in this same cycle.
            if (sample_tick && (overrun_cnt_reg != CNT_MAX)) begin
               overrun_cnt_next = overrun_cnt_reg + 1'b1;
            end
            if (!bus.fifo_full) begin
               if (win_found) begin
                  fifo_wr_next   = 1'b1;
                  fifo_data_next = win_data;
                  src_ack_next   = win_onehot;
                  grant_id_next  = win_id;
                  state_next     = WRITE;
               end else begin
                  if (underrun_cnt_reg != CNT_MAX) begin
                     underrun_cnt_next = underrun_cnt_reg + 1'b1;
                  end
`ifdef PCM_ZERO_FILL_EN
                  fifo_wr_next   = 1'b1;
                  fifo_data_next = '0;
                  state_next     = WRITE;
`else
                  state_next     = IDLE;
`endif
               end
            end
         end
         WRITE: begin
            // A tick seen during the write cycle is the pending slot.
            state_next = sample_tick ? ARB : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; aclr clears everything at once.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_reg        <= IDLE;
         fifo_wr_reg      <= 1'b0;
         fifo_data_reg    <= '0;
         src_ack_reg      <= '0;
         grant_id_reg     <= GRANT_0;
         underrun_cnt_reg <= '0;
         overrun_cnt_reg  <= '0;
      end else begin
         state_reg        <= state_next;
         fifo_wr_reg      <= fifo_wr_next;
         fifo_data_reg    <= fifo_data_next;
         src_ack_reg      <= src_ack_next;
         grant_id_reg     <= grant_id_next;
         underrun_cnt_reg <= underrun_cnt_next;
         overrun_cnt_reg  <= overrun_cnt_next;
      end
   end

   assign bus.fifo_wr   = fifo_wr_reg;
   assign bus.fifo_data = fifo_data_reg;
   assign bus.src_ack   = src_ack_reg;
   assign grant_id      = grant_id_reg;
   assign underrun_cnt  = underrun_cnt_reg;
   assign overrun_cnt   = overrun_cnt_reg;

endmodule

// File: tb/tb_pcm_src_arbiter.sv
// tb_pcm_src_arbiter
// Slot-level reference model of the PCM arbiter checked against the DUT on
// every cycle, directed scenarios with literal expectations, then a
// randomized run with rule-abiding producers.
module tb_pcm_src_arbiter;
   localparam int NS   = 4;
   localparam int DW   = 16;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk  = 1'b0;
   logic          aclr = 1'b0;
   logic          tick = 1'b0;
   logic [2:0]    grant_id;
   logic [CW-1:0] underrun_cnt;
   logic [CW-1:0] overrun_cnt;

   pcm_src_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

   pcm_src_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .aclr         (aclr),
      .sample_tick  (tick),
      .bus          (bus),
      .grant_id     (grant_id),
      .underrun_cnt (underrun_cnt),
      .overrun_cnt  (overrun_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit rand_src = 1'b0;
   logic [DW-1:0] wr_q  [$];
   logic [NS-1:0] ack_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_open: a slot is waiting to be resolved this cycle.
   // m_wr/m_data/m_ack: what the write port must show this cycle.
   logic          m_open, n_open;
   logic          m_wr, n_wr;
   logic [DW-1:0] m_data, n_data;
   logic [NS-1:0] m_ack, n_ack;
   int            m_grant, n_grant, m_under, n_under, m_over, n_over;
   logic [NS-1:0] m_req;
   int            m_w;

   function automatic int pick(input logic [NS-1:0] r, input int last);
      for (int k = 1; k <= NS; k++) begin
         int i;
         i = (last + k) % NS;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   always_comb begin
      n_open  = 1'b0;
      n_wr    = 1'b0;
      n_data  = m_data;
      n_ack   = '0;
      n_grant = m_grant;
      n_under = m_under;
      n_over  = m_over;
      m_req   = bus.src_valid & bus.src_en;
      m_w     = 0;
      if (m_open) begin
         if (tick) n_over = (m_over < CMAX) ? m_over + 1 : CMAX;
         if (bus.fifo_full) begin
            n_open = 1'b1;
         end else if (m_req != '0) begin
            m_w        = pick(m_req, m_grant);
            n_wr       = 1'b1;
            n_data     = bus.src_data[m_w*DW +: DW];
            n_ack[m_w] = 1'b1;
            n_grant    = m_w;
         end else begin
            n_under = (m_under < CMAX) ? m_under + 1 : CMAX;
`ifdef PCM_ZERO_FILL_EN
            n_wr   = 1'b1;
            n_data = '0;
`endif
         end
      end else begin
         n_open = tick;
      end
   end

   always @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         m_open  <= 1'b0;
         m_wr    <= 1'b0;
         m_data  <= '0;
         m_ack   <= '0;
         m_grant <= NS - 1;
         m_under <= 0;
         m_over  <= 0;
      end else begin
         m_open  <= n_open;
         m_wr    <= n_wr;
         m_data  <= n_data;
         m_ack   <= n_ack;
         m_grant <= n_grant;
         m_under <= n_under;
         m_over  <= n_over;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("fifo_wr", 32'(bus.fifo_wr), 32'(m_wr));
      if (m_wr) check("fifo_data", 32'(bus.fifo_data), 32'(m_data));
      check("src_ack", 32'(bus.src_ack), 32'(m_ack));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      check("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
      check("overrun_cnt", 32'(overrun_cnt), 32'(m_over));
      if (bus.fifo_wr) begin
         wr_q.push_back(bus.fifo_data);
         $display("write data=0x%04h ack=%b grant=%0d under=%0d over=%0d",
                  bus.fifo_data, bus.src_ack, grant_id, underrun_cnt, overrun_cnt);
      end
      if (bus.src_ack != '0) ack_q.push_back(bus.src_ack);
   end

   // ---------------- stimulus helpers ----------------
   task automatic update_sources();
      for (int i = 0; i < NS; i++) begin
         if (bus.src_ack[i]) begin
            bus.src_valid[i]          = 1'($urandom_range(0, 1));
            bus.src_data[i*DW +: DW]  = DW'($urandom);
         end else if (!bus.src_valid[i] && ($urandom_range(0, 2) == 0)) begin
            bus.src_valid[i]          = 1'b1;
            bus.src_data[i*DW +: DW]  = DW'($urandom);
         end
      end
   endtask

   task automatic adv();
      @(negedge clk);
      #1;
      if (rand_src) update_sources();
   endtask

   task automatic do_reset();
      aclr = 1'b0;
      tick = 1'b0;
      adv();
      adv();
      aclr = 1'b1;
      adv();
      wr_q.delete();
      ack_q.delete();
   endtask

   task automatic tick_gap(input int gap);
      tick = 1'b1;
      adv();
      tick = 1'b0;
      repeat (gap - 1) adv();
   endtask

   task automatic set_all(input logic [NS-1:0] en, input logic [NS-1:0] vld);
      bus.src_en    = en;
      bus.src_valid = vld;
      for (int i = 0; i < NS; i++) bus.src_data[i*DW +: DW] = DW'(16'h1111 * (i + 1));
   endtask

   // ---------------- test sequence ----------------
   logic [DW-1:0] exp_rr [5];
   logic [NS-1:0] exp_rr_ack [5];
   logic [DW-1:0] exp_mask [4];
   logic [NS-1:0] exp_mask_ack [4];

   initial begin
      int since;
      exp_rr       = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
      exp_rr_ack   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_mask     = '{16'h1111, 16'h3333, 16'h1111, 16'h3333};
      exp_mask_ack = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

      bus.src_en    = '0;
      bus.src_valid = '0;
      bus.src_data  = '0;
      bus.fifo_full = 1'b0;
      do_reset();
      check("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd3);
      check("rst_under", 32'(underrun_cnt), 32'd0);
      check("rst_over", 32'(overrun_cnt), 32'd0);

      // latency and reset in the middle of a write
      set_all(4'hF, 4'hF);
      tick = 1'b1;
      adv();
      tick = 1'b0;
      check("lat_arb_no_wr", 32'(bus.fifo_wr), 32'd0);
      adv();
      check("lat_wr_T2", 32'(bus.fifo_wr), 32'd1);
      check("lat_data_T2", 32'(bus.fifo_data), 32'h1111);
      aclr = 1'b0;
      #1;
      check("midrst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
      check("midrst_ack", 32'(bus.src_ack), 32'd0);
      check("midrst_grant", 32'(grant_id), 32'd3);
      check("midrst_data", 32'(bus.fifo_data), 32'd0);
      adv();
      aclr = 1'b1;
      adv();

      // round robin across all four sources
      do_reset();
      set_all(4'hF, 4'hF);
      repeat (5) tick_gap(4);
      check("rr_count", 32'(wr_q.size()), 32'd5);
      check("rr_ack_count", 32'(ack_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < wr_q.size())  check("rr_data", 32'(wr_q[i]), 32'(exp_rr[i]));
         if (i < ack_q.size()) check("rr_ack", 32'(ack_q[i]), 32'(exp_rr_ack[i]));
      end

      // enable mask 0101
      do_reset();
      set_all(4'b0101, 4'hF);
      repeat (4) tick_gap(4);
      check("mask_count", 32'(wr_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wr_q.size())  check("mask_data", 32'(wr_q[i]), 32'(exp_mask[i]));
         if (i < ack_q.size()) check("mask_ack", 32'(ack_q[i]), 32'(exp_mask_ack[i]));
      end

      // backpressure: three ticks while full, then release
      do_reset();
      set_all(4'hF, 4'hF);
      bus.fifo_full = 1'b1;
      repeat (3) tick_gap(4);
      check("bp_over", 32'(overrun_cnt), 32'd2);
      check("bp_no_write", 32'(wr_q.size()), 32'd0);
      bus.fifo_full = 1'b0;
      repeat (4) adv();
      check("bp_one_write", 32'(wr_q.size()), 32'd1);
      check("bp_over_after", 32'(overrun_cnt), 32'd2);

      // underrun: nothing valid, two ticks
      do_reset();
      set_all(4'hF, 4'h0);
      repeat (2) tick_gap(4);
      check("ur_cnt", 32'(underrun_cnt), 32'd2);
`ifdef PCM_ZERO_FILL_EN
      check("ur_fill_count", 32'(wr_q.size()), 32'd2);
      for (int i = 0; i < 2; i++)
         if (i < wr_q.size()) check("ur_fill_data", 32'(wr_q[i]), 32'd0);
      check("ur_fill_no_ack", 32'(ack_q.size()), 32'd0);
`else
      check("ur_no_write", 32'(wr_q.size()), 32'd0);
`endif

      // underrun counter saturation: 2^CW + 5 empty slots
      do_reset();
      set_all(4'hF, 4'h0);
      repeat (CMAX + 6) tick_gap(3);
      check("sat_under", 32'(underrun_cnt), 32'(CMAX));

      // randomized traffic
      do_reset();
      bus.src_en    = 4'hF;
      bus.src_valid = '0;
      rand_src      = 1'b1;
      since         = 2;
      for (int c = 0; c < 4000; c++) begin
         if (since >= 2 && ($urandom_range(0, 2) == 0)) begin
            tick  = 1'b1;
            since = 0;
         end else begin
            tick  = 1'b0;
            since++;
         end
         if ($urandom_range(0, 7) == 0) bus.fifo_full = ~bus.fifo_full;
         if ($urandom_range(0, 199) == 0) bus.src_en = NS'($urandom);
         adv();
      end
      tick          = 1'b0;
      bus.fifo_full = 1'b0;
      repeat (10) adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
